// File: rtl/mul_div_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_if
// Purpose  : Request/response bundle between the issue stage and mul_div_unit.
// Revision : 1.0
// ============================================================================
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opc;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             z_f;
    logic             s_f;
    logic             div_zero;

    modport master (
        output start, a, b, opc,
        input  busy, done, hi, lo, z_f, s_f, div_zero
    );

    modport slave (
        input  start, a, b, opc,
        output busy, done, hi, lo, z_f, s_f, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative shift-add multiplier / restoring divider with HI/LO.
// Revision : 1.0
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mul_div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OPC_MULT  = 3'b000;
    localparam logic [2:0] OPC_MULTU = 3'b001;
    localparam logic [2:0] OPC_DIV   = 3'b010;
    localparam logic [2:0] OPC_DIVU  = 3'b011;
    localparam logic [2:0] OPC_MTHI  = 3'b100;
    localparam logic [2:0] OPC_MTLO  = 3'b101;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_signed;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_z;
    logic               r_s;
    logic               r_dz;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic               w_fix_z;
    logic               w_fix_s;

    assign w_abs_a = (r_signed && r_op_a[WIDTH-1]) ? -r_op_a : r_op_a;
    assign w_abs_b = (r_signed && r_op_b[WIDTH-1]) ? -r_op_b : r_op_b;

    // Multiply: upper half accumulates, multiplier shifts out of the low half.
    assign w_add      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_op_b} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_add, r_p[WIDTH-1:1]};

    // Divide: remainder in the upper half, dividend/quotient shifts left in the low half.
    assign w_sh       = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_diff     = w_sh - {1'b0, r_op_b};
    assign w_div_next = w_diff[WIDTH] ? {w_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg_q ? -r_p : r_p;
    assign w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        w_fix_z  = (w_prod == '0);
        w_fix_s  = w_prod[2*WIDTH-1];
        if (r_is_div) begin
            // Divide by zero keeps the raw dividend, not its magnitude.
            w_fix_hi = r_div0 ? r_op_a : w_rem;
            w_fix_lo = r_div0 ? {WIDTH{1'b1}} : w_quo;
            w_fix_z  = (w_fix_lo == '0);
            w_fix_s  = w_fix_lo[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_p      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_z      <= 1'b0;
            r_s      <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.opc)
                            OPC_MULT, OPC_MULTU, OPC_DIV, OPC_DIVU: begin
                                r_signed <= ~bus.opc[0];
                                r_is_div <= bus.opc[1];
                                r_neg_q  <= ~bus.opc[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                r_neg_r  <= ~bus.opc[0] & bus.a[WIDTH-1];
                                r_div0   <= bus.opc[1] & (bus.b == '0);
                                r_op_a   <= bus.a;
                                r_op_b   <= bus.b;
                                r_cnt    <= '0;
                                r_state  <= ST_RUN;
                            end
                            OPC_MTHI: r_hi <= bus.a;
                            OPC_MTLO: r_lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // First RUN cycle forms operand magnitudes; WIDTH iteration steps follow.
                    if (r_cnt == '0) begin
                        r_p    <= {{WIDTH{1'b0}}, w_abs_a};
                        r_op_b <= w_abs_b;
                    end else begin
                        r_p <= r_is_div ? w_div_next : w_mul_next;
                    end
                    if (r_cnt == CW'(WIDTH)) begin
                        r_state <= ST_FIX;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_z     <= w_fix_z;
                    r_s     <= w_fix_s;
                    r_dz    <= r_div0;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.z_f      = r_z;
    assign bus.s_f      = r_s;
    assign bus.div_zero = r_dz;
endmodule
`default_nettype wire
